// File: rtl/alu_muldiv_ctrl_pkg.sv
// Shared encodings for the RV32IM ALU control: ALUCtl codes, ALUOp classes, divider FSM states.
// decode_alu_ctl is the single source of truth for the ALUOp/funct3/funct7 -> ALUCtl mapping.
package alu_ctrl_pkg;

  localparam logic [4:0] ALU_ADD    = 5'b00000;
  localparam logic [4:0] ALU_SLL    = 5'b00001;
  localparam logic [4:0] ALU_SLT    = 5'b00010;
  localparam logic [4:0] ALU_SLTU   = 5'b00011;
  localparam logic [4:0] ALU_XOR    = 5'b00100;
  localparam logic [4:0] ALU_SRL    = 5'b00101;
  localparam logic [4:0] ALU_OR     = 5'b00110;
  localparam logic [4:0] ALU_AND    = 5'b00111;
  localparam logic [4:0] ALU_SUB    = 5'b01000;
  localparam logic [4:0] ALU_SRA    = 5'b01101;
  localparam logic [4:0] ALU_MUL    = 5'b10000;
  localparam logic [4:0] ALU_MULH   = 5'b10001;
  localparam logic [4:0] ALU_MULHSU = 5'b10010;
  localparam logic [4:0] ALU_MULHU  = 5'b10011;
  localparam logic [4:0] ALU_DIV    = 5'b10100;
  localparam logic [4:0] ALU_DIVU   = 5'b10101;
  localparam logic [4:0] ALU_REM    = 5'b10110;
  localparam logic [4:0] ALU_REMU   = 5'b10111;

  localparam logic [1:0] ALUOP_LDST = 2'b00;
  localparam logic [1:0] ALUOP_BR   = 2'b01;
  localparam logic [1:0] ALUOP_R    = 2'b10;
  localparam logic [1:0] ALUOP_I    = 2'b11;

  localparam logic [6:0] M_FUNCT7 = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  function automatic logic [4:0] decode_alu_ctl(input logic [1:0] alu_op,
                                                input logic [6:0] f7,
                                                input logic [2:0] f3,
                                                input bit         enable_m);
    logic [4:0] ctl;
    ctl = ALU_ADD;
    case (alu_op)
      ALUOP_LDST: ctl = ALU_ADD;
      ALUOP_BR:   ctl = ALU_SUB;
      ALUOP_R: begin
        if (enable_m && f7 == M_FUNCT7) begin
          ctl = {2'b10, f3};
        end else begin
          ctl = {2'b00, f3};
          if (f7[5] && (f3 == 3'b000 || f3 == 3'b101)) ctl = ctl | ALU_SUB;
        end
      end
      ALUOP_I: begin
        // Immediates never carry the M extension; only srai borrows funct7[5].
        ctl = {2'b00, f3};
        if (f3 == 3'b101 && f7[5]) ctl = ctl | ALU_SUB;
      end
      default: ctl = ALU_ADD;
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/alu_muldiv_ctrl_if.sv
// EX-stage bundle between the core and the ALU control: decode inputs, operands, divide results.
interface alu_muldiv_ctrl_if #(
  parameter int XLEN = 32
);
  logic [1:0]      ALUOp;
  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic            instr_valid;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      ALUCtl;
  logic            use_div;
  logic            stall;
  logic [XLEN-1:0] div_result;
  logic            div_done;

  modport master (
    output ALUOp, funct7, funct3, instr_valid, op_a, op_b,
    input  ALUCtl, use_div, stall, div_result, div_done
  );

  modport slave (
    input  ALUOp, funct7, funct3, instr_valid, op_a, op_b,
    output ALUCtl, use_div, stall, div_result, div_done
  );
endinterface

// File: rtl/alu_muldiv_ctrl_serial_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; XLEN cycles after start.
// done pulses in the cycle after the final step, when q and r hold the finished result.
module serial_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] q,
  output logic [XLEN-1:0] r
);
  localparam int CW = $clog2(XLEN + 1);

  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvs;
  logic [CW-1:0]   cnt;
  logic            done_q;

  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff_lo;
  logic            fits;

  // The shifted partial remainder can exceed XLEN bits, so compare at XLEN+1.
  assign shifted = {rem, quo[XLEN-1]};
  assign fits    = shifted >= {1'b0, dvs};
  assign diff_lo = shifted[XLEN-1:0] - dvs;

  always_ff @(posedge clk) begin
    if (rst) begin
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else if (start) begin
      quo    <= a;
      rem    <= '0;
      dvs    <= b;
      cnt    <= CW'(XLEN);
      done_q <= 1'b0;
    end else if (cnt != '0) begin
      rem    <= fits ? diff_lo : shifted[XLEN-1:0];
      quo    <= {quo[XLEN-2:0], fits};
      cnt    <= cnt - CW'(1);
      done_q <= (cnt == CW'(1));
    end else begin
      done_q <= 1'b0;
    end
  end

  assign busy = (cnt != '0);
  assign done = done_q;
  assign q    = quo;
  assign r    = rem;
endmodule

// File: rtl/alu_muldiv_ctrl.sv
// RV32IM ALU control: decodes ALUCtl and sequences DIV/DIVU/REM/REMU on the serial divider,
// stalling the front end until the result retires in the DONE cycle.
module alu_muldiv_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  alu_muldiv_ctrl_if.slave  bus
);
  localparam int              CW   = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t      state, next_state;
  logic [CW-1:0]   count;
  logic            q_neg, r_neg, rem_sel, special;
  logic [XLEN-1:0] special_res;

  logic [4:0]      alu_ctl;
  logic            is_div, sign_op, rem_op;
  logic            a_neg, b_neg, div_zero, div_ovf, accept;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            stall;

  logic            dv_start, dv_busy, dv_done;
  logic [XLEN-1:0] dv_q, dv_r, q_fix, r_fix, res;

  assign alu_ctl     = decode_alu_ctl(bus.ALUOp, bus.funct7, bus.funct3, ENABLE_M);
  assign is_div      = alu_ctl[4] & alu_ctl[2];
  assign sign_op     = ~alu_ctl[0];
  assign rem_op      = alu_ctl[1];
  assign bus.ALUCtl  = alu_ctl;
  assign bus.use_div = is_div;

  assign a_neg    = sign_op & bus.op_a[XLEN-1];
  assign b_neg    = sign_op & bus.op_b[XLEN-1];
  assign a_mag    = a_neg ? -bus.op_a : bus.op_a;
  assign b_mag    = b_neg ? -bus.op_b : bus.op_b;
  assign div_zero = (bus.op_b == '0);
  assign div_ovf  = sign_op & (bus.op_a == XMIN) & (bus.op_b == '1);

  assign accept   = (state == ST_IDLE) & bus.instr_valid & is_div;
  assign dv_start = accept & ~div_zero & ~div_ovf;

  always_comb begin
    next_state = state;
    stall      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          stall      = 1'b1;
          next_state = (div_zero | div_ovf) ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall = 1'b1;
        if (count == CW'(1) || !dv_busy) next_state = ST_DONE;
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      count       <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      rem_sel     <= 1'b0;
      special     <= 1'b0;
      special_res <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        count   <= CW'(XLEN);
        q_neg   <= a_neg ^ b_neg;
        r_neg   <= a_neg;
        rem_sel <= rem_op;
        special <= div_zero | div_ovf;
        // Zero divisor wins over overflow: a -1 divisor is never zero.
        if (div_zero) special_res <= rem_op ? bus.op_a : '1;
        else          special_res <= rem_op ? '0 : XMIN;
      end else if (state == ST_BUSY) begin
        count <= count - CW'(1);
      end
    end
  end

  serial_divider #(.XLEN(XLEN)) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (dv_start),
    .a     (a_mag),
    .b     (b_mag),
    .busy  (dv_busy),
    .done  (dv_done),
    .q     (dv_q),
    .r     (dv_r)
  );

  assign q_fix = q_neg ? -dv_q : dv_q;
  assign r_fix = r_neg ? -dv_r : dv_r;
  assign res   = special ? special_res : (rem_sel ? r_fix : q_fix);

  assign bus.stall      = stall;
  assign bus.div_done   = (state == ST_DONE) & (special | dv_done);
  assign bus.div_result = bus.div_done ? res : '0;
endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Scoreboarded bench for alu_muldiv_ctrl: decode table, divide latencies, special cases, reset abort.
module tb_alu_muldiv_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [31:0] exp_q[$];

  alu_muldiv_ctrl_if #(.XLEN(32)) bus ();
  alu_muldiv_ctrl_if #(.XLEN(32)) bus_nm ();

  alu_muldiv_ctrl #(.XLEN(32), .ENABLE_M(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  alu_muldiv_ctrl #(.XLEN(32), .ENABLE_M(1'b0)) dut_nm (
    .clk (clk),
    .rst (rst),
    .bus (bus_nm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [4:0] exp;
  } dec_vec_t;

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'b100:  r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'b101:  r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110:  r = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  task automatic set_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bus.ALUOp       = 2'b10;
    bus.funct7      = 7'b0000001;
    bus.funct3      = f3;
    bus.op_a        = a;
    bus.op_b        = b;
    bus.instr_valid = 1'b1;
  endtask

  task automatic pop_check(input string name);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: div_done with empty scoreboard, got %h", name, bus.div_result);
    end else begin
      e = exp_q.pop_front();
      if (bus.div_result !== e) begin
        errors++;
        $display("FAIL %s: div_result got %h expected %h", name, bus.div_result, e);
      end
    end
  endtask

  task automatic run_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_lat, input int exp_stall,
                         input string name);
    int cycle;
    int stalls;
    bit got;
    @(posedge clk); #1;
    set_div(f3, a, b);
    exp_q.push_back(exp_res);
    cycle = 1; stalls = 0; got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (bus.stall === 1'b1) stalls++;
      if (bus.div_done === 1'b1) begin
        got = 1;
        pop_check(name);
        checks++;
        if (cycle != exp_lat) begin
          errors++;
          $display("FAIL %s latency: got %0d expected %0d", name, cycle, exp_lat);
        end
        checks++;
        if (stalls != exp_stall) begin
          errors++;
          $display("FAIL %s stall cycles: got %0d expected %0d", name, stalls, exp_stall);
        end
      end else begin
        @(posedge clk); #1;
        cycle++;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s: no div_done within 100 cycles", name);
      void'(exp_q.pop_back());
    end
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b0 || bus.div_done !== 1'b0 || bus.div_result !== 32'h0) begin
      errors++;
      $display("FAIL reset: stall=%b div_done=%b div_result=%h expected 0 0 00000000",
               bus.stall, bus.div_done, bus.div_result);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_decode();
    dec_vec_t v[9];
    v[0] = '{2'b10, 7'b0100000, 3'b000, 5'b01000};
    v[1] = '{2'b11, 7'b0100000, 3'b000, 5'b00000};
    v[2] = '{2'b10, 7'b0000001, 3'b011, 5'b10011};
    v[3] = '{2'b00, 7'b0100000, 3'b111, 5'b00000};
    v[4] = '{2'b01, 7'b0000001, 3'b100, 5'b01000};
    v[5] = '{2'b11, 7'b0100000, 3'b101, 5'b01101};
    v[6] = '{2'b10, 7'b0000000, 3'b101, 5'b00101};
    v[7] = '{2'b10, 7'b0100000, 3'b101, 5'b01101};
    v[8] = '{2'b11, 7'b0000001, 3'b100, 5'b00100};
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      bus.ALUOp = v[i].op; bus.funct7 = v[i].f7; bus.funct3 = v[i].f3;
      bus.instr_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.ALUCtl !== v[i].exp || bus.stall !== 1'b0 || bus.use_div !== 1'b0) begin
        errors++;
        $display("FAIL decode[%0d]: ALUCtl=%b stall=%b use_div=%b expected %b 0 0",
                 i, bus.ALUCtl, bus.stall, bus.use_div, v[i].exp);
      end
    end
    // A divide decode without instr_valid must not start or stall.
    @(posedge clk); #1;
    set_div(3'b100, 32'd9, 32'd3);
    bus.instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.ALUCtl !== 5'b10100 || bus.use_div !== 1'b1 || bus.stall !== 1'b0 || bus.div_done !== 1'b0) begin
      errors++;
      $display("FAIL decode_noval: ALUCtl=%b use_div=%b stall=%b done=%b expected 10100 1 0 0",
               bus.ALUCtl, bus.use_div, bus.stall, bus.div_done);
    end
  endtask

  task automatic test_div();
    run_div(3'b100, -32'sd7, 32'd2, 32'hFFFF_FFFD, 34, 33, "div_m7_2");
    run_div(3'b110, -32'sd7, 32'd2, 32'hFFFF_FFFF, 34, 33, "rem_m7_2");
    run_div(3'b100, 32'd7, -32'sd2, 32'hFFFF_FFFD, 34, 33, "div_7_m2");
    run_div(3'b110, 32'd7, -32'sd2, 32'd1, 34, 33, "rem_7_m2");
  endtask

  task automatic test_divu();
    run_div(3'b101, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 34, 33, "divu_max_16");
    run_div(3'b111, 32'hFFFF_FFFF, 32'd16, 32'd15, 34, 33, "remu_max_16");
  endtask

  task automatic test_special();
    run_div(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, 1, "div_by_zero");
    run_div(3'b110, 32'd5, 32'd0, 32'd5, 2, 1, "rem_by_zero");
    run_div(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, 1, "divu_by_zero");
    run_div(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 1, "div_ovf");
    run_div(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 2, 1, "rem_ovf");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [2:0]  f3;
    int lat;
    for (int i = 0; i < 6; i++) begin
      a  = $urandom;
      b  = $urandom >> $urandom_range(0, 28);
      f3 = 3'(4 + $urandom_range(0, 3));
      lat = (b == 0) ? 2 : 34;
      run_div(f3, a, b, model(f3, a, b), lat, lat - 1, "random");
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(posedge clk); #1;
    set_div(3'b101, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid busy: stall=%b expected 1", bus.stall);
    end
    rst = 1'b1;
    bus.instr_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b0 || bus.div_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid after: stall=%b div_done=%b expected 0 0", bus.stall, bus.div_done);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.div_done === 1'b1 || bus.stall === 1'b1) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_mid abandon: div_done/stall seen=1 expected 0");
    end
    run_div(3'b101, 32'd100, 32'd7, 32'd14, 34, 33, "divu_after_reset");
  endtask

  task automatic test_back_to_back();
    int cycle;
    int first;
    int n;
    @(posedge clk); #1;
    set_div(3'b100, 32'd100, 32'd7);
    exp_q.push_back(32'd14);
    exp_q.push_back(32'd14);
    cycle = 1; n = 0; first = 0;
    for (int i = 0; i < 200 && n < 2; i++) begin
      @(negedge clk);
      if (bus.div_done === 1'b1) begin
        pop_check("b2b");
        if (n == 0) begin
          first = cycle;
        end else begin
          checks++;
          if (cycle - first != 34) begin
            errors++;
            $display("FAIL b2b spacing: got %0d expected 34", cycle - first);
          end
        end
        n++;
      end
      @(posedge clk); #1;
      cycle++;
    end
    bus.instr_valid = 1'b0;
    if (n < 2) begin
      checks++; errors++;
      $display("FAIL b2b: only %0d div_done pulses within 200 cycles", n);
      exp_q.delete();
    end
  endtask

  task automatic test_no_m();
    bit bad;
    @(posedge clk); #1;
    bus_nm.ALUOp = 2'b10; bus_nm.funct7 = 7'b0000001; bus_nm.funct3 = 3'b100;
    bus_nm.op_a = 32'd10; bus_nm.op_b = 32'd3; bus_nm.instr_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_nm.ALUCtl !== 5'b00100 || bus_nm.use_div !== 1'b0) begin
      errors++;
      $display("FAIL no_m decode: ALUCtl=%b use_div=%b expected 00100 0", bus_nm.ALUCtl, bus_nm.use_div);
    end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_nm.stall === 1'b1 || bus_nm.div_done === 1'b1) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL no_m stall: stall/div_done asserted=1 expected 0");
    end
    bus_nm.instr_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.ALUOp = 2'b00; bus.funct7 = '0; bus.funct3 = '0;
    bus.op_a = '0; bus.op_b = '0; bus.instr_valid = 1'b0;
    bus_nm.ALUOp = 2'b00; bus_nm.funct7 = '0; bus_nm.funct3 = '0;
    bus_nm.op_a = '0; bus_nm.op_b = '0; bus_nm.instr_valid = 1'b0;

    test_reset();
    test_decode();
    test_div();
    test_divu();
    test_special();
    test_random();
    test_reset_mid();
    test_back_to_back();
    test_no_m();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d results never returned, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
